// File: rtl/merlin_arb_defs_pkg.sv
// Shared definitions for the merlin memory arbiter: source tags and request size constants.
package merlin_arb_defs;

  localparam logic MERLIN_ARB_SRC_I = 1'b0;
  localparam logic MERLIN_ARB_SRC_D = 1'b1;

  localparam logic [1:0] MERLIN_ARB_SIZE_WORD = 2'b10;

  // Tie-break winner given the master that won the previous transfer.
  function automatic logic merlin_arb_other(input logic src);
    return (src == MERLIN_ARB_SRC_I) ? MERLIN_ARB_SRC_D : MERLIN_ARB_SRC_I;
  endfunction

endpackage

// File: rtl/merlin_arb_order_fifo.sv
// In-order 1-bit source-tag FIFO; records which master issued each outstanding request.
module merlin_arb_order_fifo #(
  parameter int C_FIFO_DEPTH_X = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic dout,
  output logic full,
  output logic empty
);

  localparam int DEPTH = 1 << C_FIFO_DEPTH_X;
  localparam logic [C_FIFO_DEPTH_X:0] FULL_COUNT = (C_FIFO_DEPTH_X+1)'(DEPTH);

  logic [DEPTH-1:0]          mem;
  logic [C_FIFO_DEPTH_X-1:0] wr_ptr;
  logic [C_FIFO_DEPTH_X-1:0] rd_ptr;
  logic [C_FIFO_DEPTH_X:0]   count;
  logic                      do_push;
  logic                      do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/merlin_mem_arbiter.sv
// Two-master (instruction/data) to one-slave memory arbiter with in-order response routing.
// Define MERLIN_ARB_ROUND_ROBIN_EN for round-robin ties; otherwise data always wins ties.
module merlin_mem_arbiter
  import merlin_arb_defs::*;
#(
  parameter int C_FIFO_DEPTH_X = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        clk_en_i,

  output logic        i_reqready_o,
  input  logic        i_reqvalid_i,
  input  logic [1:0]  i_reqhpl_i,
  input  logic [31:0] i_reqaddr_i,
  input  logic        i_rspready_i,
  output logic        i_rspvalid_o,
  output logic        i_rsprerr_o,
  output logic [31:0] i_rspdata_o,

  output logic        d_reqready_o,
  input  logic        d_reqvalid_i,
  input  logic [1:0]  d_reqsize_i,
  input  logic        d_reqwrite_i,
  input  logic [1:0]  d_reqhpl_i,
  input  logic [31:0] d_reqaddr_i,
  input  logic [31:0] d_reqdata_i,
  input  logic        d_rspready_i,
  output logic        d_rspvalid_o,
  output logic        d_rsprerr_o,
  output logic        d_rspwerr_o,
  output logic [31:0] d_rspdata_o,

  input  logic        m_reqready_i,
  output logic        m_reqvalid_o,
  output logic [1:0]  m_reqsize_o,
  output logic        m_reqwrite_o,
  output logic [1:0]  m_reqhpl_o,
  output logic [31:0] m_reqaddr_o,
  output logic [31:0] m_reqdata_o,
  output logic        m_rspready_o,
  input  logic        m_rspvalid_i,
  input  logic        m_rsprerr_i,
  input  logic        m_rspwerr_i,
  input  logic [31:0] m_rspdata_i
);

  logic lock;
  logic lock_src;
  logic grant;
  logic tie_winner;
  logic sel_valid;
  logic req_ok;
  logic req_xfer;
  logic rsp_xfer;
  logic fifo_full;
  logic fifo_empty;
  logic head_src;

`ifdef MERLIN_ARB_ROUND_ROBIN_EN
  logic rr_last;

  assign tie_winner = merlin_arb_other(rr_last);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rr_last <= MERLIN_ARB_SRC_I;
    end else if (req_xfer) begin
      rr_last <= grant;
    end
  end
`else
  assign tie_winner = MERLIN_ARB_SRC_D;
`endif

  // A presented but unaccepted request pins the grant so the slave sees a stable payload.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      lock     <= 1'b0;
      lock_src <= MERLIN_ARB_SRC_I;
    end else if (clk_en_i) begin
      if (req_xfer) begin
        lock <= 1'b0;
      end else if (m_reqvalid_o) begin
        lock     <= 1'b1;
        lock_src <= grant;
      end
    end
  end

  always_comb begin
    grant = MERLIN_ARB_SRC_D;
    if (lock) begin
      grant = lock_src;
    end else if (i_reqvalid_i && d_reqvalid_i) begin
      grant = tie_winner;
    end else if (i_reqvalid_i) begin
      grant = MERLIN_ARB_SRC_I;
    end
  end

  always_comb begin
    sel_valid    = i_reqvalid_i;
    m_reqsize_o  = MERLIN_ARB_SIZE_WORD;
    m_reqwrite_o = 1'b0;
    m_reqhpl_o   = i_reqhpl_i;
    m_reqaddr_o  = i_reqaddr_i;
    m_reqdata_o  = '0;
    if (grant == MERLIN_ARB_SRC_D) begin
      sel_valid    = d_reqvalid_i;
      m_reqsize_o  = d_reqsize_i;
      m_reqwrite_o = d_reqwrite_i;
      m_reqhpl_o   = d_reqhpl_i;
      m_reqaddr_o  = d_reqaddr_i;
      m_reqdata_o  = d_reqdata_i;
    end
  end

  // Stall decision uses the registered full flag only, so a same-cycle pop cannot release it.
  assign m_reqvalid_o = sel_valid & ~fifo_full;
  assign req_ok       = m_reqready_i & ~fifo_full & clk_en_i;
  assign i_reqready_o = (grant == MERLIN_ARB_SRC_I) & i_reqvalid_i & req_ok;
  assign d_reqready_o = (grant == MERLIN_ARB_SRC_D) & d_reqvalid_i & req_ok;
  assign req_xfer     = m_reqvalid_o & m_reqready_i & clk_en_i;

  always_comb begin
    i_rspvalid_o = 1'b0;
    d_rspvalid_o = 1'b0;
    m_rspready_o = 1'b0;
    if (!fifo_empty) begin
      if (head_src == MERLIN_ARB_SRC_D) begin
        d_rspvalid_o = m_rspvalid_i;
        m_rspready_o = d_rspready_i & clk_en_i;
      end else begin
        i_rspvalid_o = m_rspvalid_i;
        m_rspready_o = i_rspready_i & clk_en_i;
      end
    end
  end

  assign rsp_xfer    = m_rspvalid_i & m_rspready_o;

  assign i_rsprerr_o = m_rsprerr_i;
  assign i_rspdata_o = m_rspdata_i;
  assign d_rsprerr_o = m_rsprerr_i;
  assign d_rspwerr_o = m_rspwerr_i;
  assign d_rspdata_o = m_rspdata_i;

  merlin_arb_order_fifo #(
    .C_FIFO_DEPTH_X(C_FIFO_DEPTH_X)
  ) u_order_fifo (
    .clk  (clk_i),
    .reset(reset_i),
    .push (req_xfer),
    .pop  (rsp_xfer),
    .din  (grant),
    .dout (head_src),
    .full (fifo_full),
    .empty(fifo_empty)
  );

endmodule

// File: tb/tb_merlin_mem_arbiter.sv
// Bench for merlin_mem_arbiter: directed scenarios then random traffic against a transaction-level model.
module tb_merlin_mem_arbiter;

  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        reset_i, clk_en_i;
  logic        i_reqready_o, i_reqvalid_i, i_rspready_i, i_rspvalid_o, i_rsprerr_o;
  logic [1:0]  i_reqhpl_i;
  logic [31:0] i_reqaddr_i, i_rspdata_o;
  logic        d_reqready_o, d_reqvalid_i, d_reqwrite_i, d_rspready_i;
  logic        d_rspvalid_o, d_rsprerr_o, d_rspwerr_o;
  logic [1:0]  d_reqsize_i, d_reqhpl_i;
  logic [31:0] d_reqaddr_i, d_reqdata_i, d_rspdata_o;
  logic        m_reqready_i, m_reqvalid_o, m_reqwrite_o, m_rspready_o;
  logic        m_rspvalid_i, m_rsprerr_i, m_rspwerr_i;
  logic [1:0]  m_reqsize_o, m_reqhpl_o;
  logic [31:0] m_reqaddr_o, m_reqdata_o, m_rspdata_i;

  int checks = 0;
  int errors = 0;

  // Model: queue of outstanding source tags (0=I, 1=D) plus the "request left waiting" rule.
  bit          tagq[$];
  bit          pend;
  bit          pend_src;
  bit          rr_last;
  logic [1:0]  held_size, held_hpl;
  logic        held_write;
  logic [31:0] held_addr, held_data;

  always #5 clk_i = ~clk_i;

  merlin_mem_arbiter #(.C_FIFO_DEPTH_X(2)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .clk_en_i(clk_en_i),
    .i_reqready_o(i_reqready_o), .i_reqvalid_i(i_reqvalid_i), .i_reqhpl_i(i_reqhpl_i),
    .i_reqaddr_i(i_reqaddr_i), .i_rspready_i(i_rspready_i), .i_rspvalid_o(i_rspvalid_o),
    .i_rsprerr_o(i_rsprerr_o), .i_rspdata_o(i_rspdata_o),
    .d_reqready_o(d_reqready_o), .d_reqvalid_i(d_reqvalid_i), .d_reqsize_i(d_reqsize_i),
    .d_reqwrite_i(d_reqwrite_i), .d_reqhpl_i(d_reqhpl_i), .d_reqaddr_i(d_reqaddr_i),
    .d_reqdata_i(d_reqdata_i), .d_rspready_i(d_rspready_i), .d_rspvalid_o(d_rspvalid_o),
    .d_rsprerr_o(d_rsprerr_o), .d_rspwerr_o(d_rspwerr_o), .d_rspdata_o(d_rspdata_o),
    .m_reqready_i(m_reqready_i), .m_reqvalid_o(m_reqvalid_o), .m_reqsize_o(m_reqsize_o),
    .m_reqwrite_o(m_reqwrite_o), .m_reqhpl_o(m_reqhpl_o), .m_reqaddr_o(m_reqaddr_o),
    .m_reqdata_o(m_reqdata_o), .m_rspready_o(m_rspready_o), .m_rspvalid_i(m_rspvalid_i),
    .m_rsprerr_i(m_rsprerr_i), .m_rspwerr_i(m_rspwerr_i), .m_rspdata_i(m_rspdata_i)
  );

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic setIdle();
    reset_i = 1'b0;       clk_en_i = 1'b1;
    i_reqvalid_i = 1'b0;  i_reqhpl_i = 2'd0;   i_reqaddr_i = '0;  i_rspready_i = 1'b0;
    d_reqvalid_i = 1'b0;  d_reqsize_i = 2'd0;  d_reqwrite_i = 1'b0;
    d_reqhpl_i = 2'd0;    d_reqaddr_i = '0;    d_reqdata_i = '0;  d_rspready_i = 1'b0;
    m_reqready_i = 1'b0;  m_rspvalid_i = 1'b0; m_rsprerr_i = 1'b0;
    m_rspwerr_i = 1'b0;   m_rspdata_i = '0;
  endtask

  // Masters must keep a waiting request valid and unchanged until it is accepted.
  task automatic applyStimulus();
    if (pend) begin
      if (pend_src) begin
        d_reqvalid_i = 1'b1;      d_reqsize_i = held_size; d_reqwrite_i = held_write;
        d_reqhpl_i = held_hpl;    d_reqaddr_i = held_addr; d_reqdata_i = held_data;
      end else begin
        i_reqvalid_i = 1'b1;      i_reqhpl_i = held_hpl;   i_reqaddr_i = held_addr;
      end
    end
    #2;
  endtask

  task automatic checkOutput();
    bit          full, empty, w, wvalid, e_mvalid, e_mrspready, req_x, rsp_x;
    logic [1:0]  e_size, e_hpl;
    logic        e_write;
    logic [31:0] e_addr, e_data;
    full  = (tagq.size() == DEPTH);
    empty = (tagq.size() == 0);
    if (pend)                             w = pend_src;
    else if (i_reqvalid_i && d_reqvalid_i) begin
`ifdef MERLIN_ARB_ROUND_ROBIN_EN
      w = !rr_last;
`else
      w = 1'b1;
`endif
    end
    else if (i_reqvalid_i)                w = 1'b0;
    else                                  w = 1'b1;
    wvalid   = w ? d_reqvalid_i : i_reqvalid_i;
    e_mvalid = wvalid && !full;
    e_size   = w ? d_reqsize_i : 2'b10;
    e_write  = w ? d_reqwrite_i : 1'b0;
    e_hpl    = w ? d_reqhpl_i : i_reqhpl_i;
    e_addr   = w ? d_reqaddr_i : i_reqaddr_i;
    e_data   = w ? d_reqdata_i : 32'h0;

    checkVal("m_reqvalid", m_reqvalid_o, e_mvalid);
    checkVal("i_reqready", i_reqready_o, e_mvalid && !w && m_reqready_i && clk_en_i);
    checkVal("d_reqready", d_reqready_o, e_mvalid && w && m_reqready_i && clk_en_i);
    if (e_mvalid) begin
      checkVal("m_reqaddr", m_reqaddr_o, e_addr);
      checkVal("m_reqdata", m_reqdata_o, e_data);
      checkVal("m_reqsize", 32'(m_reqsize_o), 32'(e_size));
      checkVal("m_reqwrite", 32'(m_reqwrite_o), 32'(e_write));
      checkVal("m_reqhpl", 32'(m_reqhpl_o), 32'(e_hpl));
    end

    e_mrspready = !empty && clk_en_i && (tagq[0] ? d_rspready_i : i_rspready_i);
    checkVal("m_rspready", m_rspready_o, e_mrspready);
    checkVal("i_rspvalid", i_rspvalid_o, m_rspvalid_i && !empty && !tagq[0]);
    checkVal("d_rspvalid", d_rspvalid_o, m_rspvalid_i && !empty && tagq[0]);
    checkVal("i_rspdata", i_rspdata_o, m_rspdata_i);
    checkVal("d_rspdata", d_rspdata_o, m_rspdata_i);
    checkVal("rsp_err", {i_rsprerr_o, d_rsprerr_o, d_rspwerr_o},
             {m_rsprerr_i, m_rsprerr_i, m_rspwerr_i});

    req_x = e_mvalid && m_reqready_i && clk_en_i;
    rsp_x = m_rspvalid_i && e_mrspready;
    @(posedge clk_i);
    if (reset_i) begin
      tagq.delete();
      pend = 1'b0;
      rr_last = 1'b0;
    end else if (clk_en_i) begin
      if (rsp_x) void'(tagq.pop_front());
      if (req_x) begin
        tagq.push_back(w);
        pend = 1'b0;
        rr_last = w;
      end else if (e_mvalid) begin
        pend = 1'b1;      pend_src = w;
        held_size = e_size; held_write = e_write; held_hpl = e_hpl;
        held_addr = e_addr; held_data = e_data;
      end
    end
    #1;
  endtask

  task automatic drain();
    for (int n = 0; n < 2 * DEPTH && tagq.size() > 0; n++) begin
      setIdle();
      m_rspvalid_i = 1'b1; i_rspready_i = 1'b1; d_rspready_i = 1'b1;
      applyStimulus(); checkOutput();
    end
    checkVal("drained", tagq.size(), 0);
  endtask

  initial begin
    setIdle();
    reset_i = 1'b1;
    pend = 1'b0; rr_last = 1'b0; pend_src = 1'b0;
    @(posedge clk_i); #1;

    $display("[TB] reset state");
    setIdle(); reset_i = 1'b1; m_reqready_i = 1'b1; i_rspready_i = 1'b1; d_rspready_i = 1'b1;
    applyStimulus(); checkOutput();

    $display("[TB] single instruction request and response");
    setIdle(); i_reqvalid_i = 1'b1; i_reqaddr_i = 32'h100; m_reqready_i = 1'b1;
    applyStimulus();
    checkVal("tp_addr", m_reqaddr_o, 32'h100);
    checkVal("tp_size", 32'(m_reqsize_o), 32'd2);
    checkOutput();
    setIdle(); m_rspvalid_i = 1'b1; m_rspdata_i = 32'h13; i_rspready_i = 1'b1;
    applyStimulus();
    checkVal("tp_ivalid", i_rspvalid_o, 1'b1);
    checkVal("tp_idata", i_rspdata_o, 32'h13);
    checkVal("tp_dvalid", d_rspvalid_o, 1'b0);
    checkOutput();

    $display("[TB] both masters requesting every cycle");
    for (int c = 0; c < 6; c++) begin
      setIdle();
      i_reqvalid_i = 1'b1; i_reqaddr_i = 32'h2000 + 32'(c * 4);
      d_reqvalid_i = 1'b1; d_reqaddr_i = 32'h8000 + 32'(c * 4); d_reqsize_i = 2'b01;
      m_reqready_i = 1'b1; m_rspvalid_i = 1'b1; i_rspready_i = 1'b1; d_rspready_i = 1'b1;
      applyStimulus(); checkOutput();
    end
    drain();

    $display("[TB] stalled data request holds the grant");
    for (int c = 0; c < 5; c++) begin
      setIdle();
      d_reqvalid_i = (c < 4); d_reqaddr_i = 32'hD000_0040; d_reqwrite_i = 1'b1;
      d_reqdata_i = 32'hCAFE_0001; d_reqsize_i = 2'b10;
      i_reqvalid_i = (c >= 1); i_reqaddr_i = 32'h0000_0300;
      m_reqready_i = (c >= 3);
      applyStimulus();
      if (c < 4) checkVal("stall_addr", m_reqaddr_o, 32'hD000_0040);
      else       checkVal("then_i_addr", m_reqaddr_o, 32'h0000_0300);
      checkOutput();
    end
    drain();

    $display("[TB] fill the order FIFO");
    for (int c = 0; c < DEPTH; c++) begin
      setIdle(); i_reqvalid_i = 1'b1; i_reqaddr_i = 32'h400 + 32'(c); m_reqready_i = 1'b1;
      applyStimulus(); checkOutput();
    end
    setIdle(); i_reqvalid_i = 1'b1; d_reqvalid_i = 1'b1; m_reqready_i = 1'b1;
    m_rspvalid_i = 1'b1; i_rspready_i = 1'b1;
    applyStimulus();
    checkVal("full_mvalid", m_reqvalid_o, 1'b0);
    checkVal("full_iready", i_reqready_o, 1'b0);
    checkVal("full_dready", d_reqready_o, 1'b0);
    checkOutput();
    setIdle(); i_reqvalid_i = 1'b1; m_reqready_i = 1'b1;
    applyStimulus();
    checkVal("resume_mvalid", m_reqvalid_o, 1'b1);
    checkOutput();
    drain();

    $display("[TB] reset with outstanding transactions");
    for (int c = 0; c < 3; c++) begin
      setIdle(); d_reqvalid_i = 1'b1; d_reqaddr_i = 32'h900 + 32'(c); m_reqready_i = 1'b1;
      applyStimulus(); checkOutput();
    end
    setIdle(); reset_i = 1'b1;
    applyStimulus(); checkOutput();
    setIdle(); m_rspvalid_i = 1'b1; i_rspready_i = 1'b1; d_rspready_i = 1'b1;
    applyStimulus();
    checkVal("stray_rspready", m_rspready_o, 1'b0);
    checkOutput();

    $display("[TB] random traffic");
    for (int c = 0; c < 600; c++) begin
      setIdle();
      reset_i      = ($urandom_range(0, 99) == 0);
      clk_en_i     = ($urandom_range(0, 9) != 0);
      i_reqvalid_i = ($urandom_range(0, 2) != 0);
      i_reqhpl_i   = 2'($urandom);
      i_reqaddr_i  = $urandom;
      d_reqvalid_i = ($urandom_range(0, 2) != 0);
      d_reqsize_i  = 2'($urandom);
      d_reqwrite_i = 1'($urandom);
      d_reqhpl_i   = 2'($urandom);
      d_reqaddr_i  = $urandom;
      d_reqdata_i  = $urandom;
      m_reqready_i = ($urandom_range(0, 9) < 7);
      m_rspvalid_i = ($urandom_range(0, 9) < 6);
      m_rsprerr_i  = 1'($urandom);
      m_rspwerr_i  = 1'($urandom);
      m_rspdata_i  = $urandom;
      i_rspready_i = ($urandom_range(0, 3) != 0);
      d_rspready_i = ($urandom_range(0, 3) != 0);
      applyStimulus(); checkOutput();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/merlin_mem_arbiter.md
# merlin_mem_arbiter

Two-master, one-slave arbiter that shares a single split request/response memory port between the core's instruction fetch port and its load/store data port. Sits between the core top level and the memory/interconnect. An in-order source-tag FIFO routes every response back to the master that issued it. Supports up to 2^C_FIFO_DEPTH_X outstanding transactions.

## Interface
- C_FIFO_DEPTH_X, 2 — log2 of the maximum number of outstanding transactions (order FIFO depth)
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- clk_en_i  in  1  clock enable; state changes and transfers only when high
- i_reqready_o  out  1  instruction request accepted
- i_reqvalid_i, i_reqhpl_i[1:0], i_reqaddr_i[31:0]  in  instruction request
- i_rspready_i  in  1;  i_rspvalid_o, i_rsprerr_o, i_rspdata_o[31:0]  out  instruction response
- d_reqready_o  out  1  data request accepted
- d_reqvalid_i, d_reqsize_i[1:0], d_reqwrite_i, d_reqhpl_i[1:0], d_reqaddr_i[31:0], d_reqdata_i[31:0]  in  data request
- d_rspready_i  in  1;  d_rspvalid_o, d_rsprerr_o, d_rspwerr_o, d_rspdata_o[31:0]  out  data response
- m_reqready_i  in  1;  m_reqvalid_o, m_reqsize_o[1:0], m_reqwrite_o, m_reqhpl_o[1:0], m_reqaddr_o[31:0], m_reqdata_o[31:0]  out  shared request
- m_rspready_o  out  1;  m_rspvalid_i, m_rsprerr_i, m_rspwerr_i, m_rspdata_i[31:0]  in  shared response

## Operation
- Transfer on any channel = valid & ready & clk_en_i at a rising clk_i.
- Request path is a combinational mux on grant `g` (I or D). Instruction requests drive size=2'b10, write=0, data=0.
- Arbitration, when not locked: only one requester valid → it wins. Both valid → see Configuration.
- Lock: if m_reqvalid_o is high and no transfer occurs, a `lock` register holds `g` for the next cycle. Masters keep valid and payload stable until accepted. Lock clears on transfer.
- Order FIFO: a 1-bit source tag (0=I, 1=D) is pushed on each m_req transfer.
- FIFO full → m_reqvalid_o=0 and both reqready_o=0. A pop in the same cycle does not un-stall; the stall is based on registered full only.
- The non-granted master's reqready_o is 0. The granted master's reqready_o = m_reqready_i & ~full & clk_en_i.
- Response routing by FIFO head:
  - rspvalid goes to the head master only; the other master sees rspvalid=0.
  - m_rspready_o = head master's rspready & ~empty & clk_en_i.
  - The FIFO pops on each m_rsp transfer.
- FIFO empty → m_rspready_o=0; stray slave responses are not consumed.
- Response data/error fields are fanned out to both masters unmodified.
- Push and pop in the same cycle (not full) → occupancy unchanged.
- Pointers wrap modulo 2^C_FIFO_DEPTH_X; occupancy counter is C_FIFO_DEPTH_X+1 bits wide.

## Timing
- Request: zero-cycle combinational grant-to-slave path. Response: zero-cycle combinational path.
- Reset: FIFO empty, lock=0, rr_last=I. All outputs are then combinational; with no inputs valid, every valid and ready output is 0.
- Reset asserted mid-transaction: FIFO is flushed and lock cleared on that edge. The slave must be reset concurrently; outstanding responses are discarded.
- clk_en_i low: all registers hold and all ready outputs are 0. m_reqvalid_o still reflects the current grant.
- Back-to-back transfers, one per cycle, until the FIFO is full.

## Configuration
- MERLIN_ARB_ROUND_ROBIN_EN defined:
  - Ties alternate via register `rr_last`, updated on each m_req transfer.
  - Winner = master ≠ rr_last. The first tie after reset goes to D.
- Undefined: fixed priority, D always wins ties; no rr_last register.

## Structure
- Shared package/header `merlin_arb_defs`:
  - source tag constants MERLIN_ARB_SRC_I=1'b0, MERLIN_ARB_SRC_D=1'b1
  - size constant for a word (2'b10)
- Sub-module `merlin_arb_order_fifo`: 1-bit-wide synchronous FIFO, parameterised by C_FIFO_DEPTH_X, with full/empty outputs.
- Arbitration, lock and muxing live in the top module.

## Test plan
- Single I request addr=0x100, m_reqready_i=1 → m_reqaddr_o=0x100, size=2, write=0 the same cycle. Response data 0x13 → i_rspvalid_o=1, i_rspdata_o=0x13, d_rspvalid_o=0.
- I and D valid every cycle, always ready:
  - with the macro: grants D,I,D,I
  - without the macro: D every cycle, I starved
- D request with m_reqready_i=0 for 3 cycles while I becomes valid → grant stays D with payload stable; transfer on cycle 4, then I is served.
- 4 transfers with no responses (depth 4) → both reqready_o=0 and m_reqvalid_o=0. One response pops → requests resume next cycle.
- Issue I, D, I; slave responds in order → responses arrive at I, D, I respectively. Holding d_rspready_i=0 stalls m_rspready_o.
- Reset asserted with 3 outstanding → FIFO empty; a stray m_rspvalid_i=1 yields m_rspready_o=0.
